// File: rtl/foc_pkg.sv
// Shared FOC constants and the clarke_park state encoding.
package foc_pkg;

    localparam int W       = 16;  // Q1.15 data width
    localparam int MUL_A_W = 18;  // wide multiplier operand (holds Ia + 2*Ib)
    localparam int ACC_W   = 33;  // product / accumulator width

    localparam logic signed [W-1:0] INV_SQRT3_Q15 = 16'sd18919;  // 1/sqrt(3), Q0.15
    localparam logic signed [W-1:0] SAT_MAX       = 16'sh7fff;
    localparam logic signed [W-1:0] SAT_MIN       = 16'sh8000;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_BETA,
        ST_D1,
        ST_D2,
        ST_Q1,
        ST_Q2,
        ST_OUT
    } cp_state_t;

endpackage

// File: rtl/q15_round_sat.sv
// Rounds a 33-bit Q2.30-style product sum back to Q1.15:
// add 2^14, arithmetic shift right by 15, clamp to the 16-bit range.
module q15_round_sat
    import foc_pkg::*;
(
    input  logic signed [ACC_W-1:0] din,
    output logic signed [W-1:0]     dout
);

    localparam int SH_W = ACC_W + 1 - 15;  // width left after the shift

    logic signed [ACC_W:0]  rounded;
    logic signed [SH_W-1:0] shifted;

    // Round half toward +inf, then saturate.
    always_comb begin
        // NOTE: every variable gets a value on every path through an always_comb, otherwise a latch is inferred.
        rounded = (ACC_W+1)'(din) + (ACC_W+1)'(32'sd16384);
        shifted = rounded[ACC_W:15];
        dout    = shifted[W-1:0];
        if (shifted > SH_W'(SAT_MAX)) begin
            dout = SAT_MAX;
        end else if (shifted < SH_W'(SAT_MIN)) begin
            dout = SAT_MIN;
        end
    end

endmodule

// File: rtl/clarke_park.sv
// Clarke + Park transform on one shared 18x16 signed multiplier.
// Sequence: BETA -> D1 -> D2 -> Q1 -> Q2 -> OUT, one cycle each.
module clarke_park
    import foc_pkg::*;
(
    input  logic        iClk,
    input  logic        iRst_n,
    input  logic        iEn,
    input  logic [15:0] iIa,
    input  logic [15:0] iIb,
    input  logic [15:0] iSin,
    input  logic [15:0] iCos,
    output logic [15:0] oId,
    output logic [15:0] oIq,
    output logic        oDone,
    output logic        oBusy
);

    cp_state_t state, state_next;

    logic signed [W-1:0]       ia, ib, sin_r, cos_r, beta;
    logic signed [ACC_W-1:0]   acc, id_raw;
    logic signed [MUL_A_W-1:0] s_sum, mul_a;
    logic signed [W-1:0]       mul_b;
    logic signed [ACC_W-1:0]   product;
    logic signed [ACC_W-1:0]   rs0_in;
    logic signed [W-1:0]       rs0_out, rs1_out;

    // Ia + 2*Ib needs 18 bits to never wrap.
    assign s_sum = MUL_A_W'(ia) + (MUL_A_W'(ib) <<< 1);

    // Operand mux for the single shared multiplier.
    always_comb begin
        mul_a = s_sum;
        mul_b = INV_SQRT3_Q15;
        case (state)
            ST_D1:   begin mul_a = MUL_A_W'(ia);   mul_b = cos_r; end
            ST_D2:   begin mul_a = MUL_A_W'(beta); mul_b = sin_r; end
            ST_Q1:   begin mul_a = MUL_A_W'(ia);   mul_b = sin_r; end
            ST_Q2:   begin mul_a = MUL_A_W'(beta); mul_b = cos_r; end
            default: ;
        endcase
    end

    // Every product here is bounded well below 2^32, so 33 bits are exact.
    assign product = ACC_W'(mul_a) * ACC_W'(mul_b);

    // The first rounder produces beta in BETA and Id in OUT.
    assign rs0_in = (state == ST_BETA) ? product : id_raw;

    q15_round_sat u_rs_d (.din(rs0_in), .dout(rs0_out));
    q15_round_sat u_rs_q (.din(acc),    .dout(rs1_out));

    // State register.
    always_ff @(posedge iClk or negedge iRst_n) begin
        if (!iRst_n) begin
            state <= ST_IDLE;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
            state <= state_next;
        end
    end

    // Next-state: wait for a start in IDLE, then step once per cycle.
    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: if (iEn) state_next = ST_BETA;
            ST_BETA: state_next = ST_D1;
            ST_D1:   state_next = ST_D2;
            ST_D2:   state_next = ST_Q1;
            ST_Q1:   state_next = ST_Q2;
            ST_Q2:   state_next = ST_OUT;
            ST_OUT:  state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    // Sample latch, multiply-accumulate steps and registered outputs.
    always_ff @(posedge iClk or negedge iRst_n) begin
        if (!iRst_n) begin
            ia     <= '0;
            ib     <= '0;
            sin_r  <= '0;
            cos_r  <= '0;
            beta   <= '0;
            acc    <= '0;
            id_raw <= '0;
            oId    <= '0;
            oIq    <= '0;
            oDone  <= 1'b0;
            oBusy  <= 1'b0;
        end else begin
            oDone <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (iEn) begin
                        ia    <= $signed(iIa);
                        ib    <= $signed(iIb);
                        sin_r <= $signed(iSin);
                        cos_r <= $signed(iCos);
                        oBusy <= 1'b1;
                    end
                end
                ST_BETA: beta <= rs0_out;
                ST_D1:   acc  <= product;
                ST_D2: begin
                    acc    <= acc + product;
                    id_raw <= acc + product;
                end
                // Negating the 33-bit product keeps -(-32768 * -32768) representable.
                ST_Q1:   acc <= -product;
                ST_Q2:   acc <= acc + product;
                ST_OUT: begin
                    oId   <= rs0_out;
                    oIq   <= rs1_out;
                    oDone <= 1'b1;
                    oBusy <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: doc/clarke_park.md
# clarke_park

Current-frame transform stage that sits directly downstream of the encoder data-treatment stage. On each start pulse, issued when the encoder stage's CORDIC reports done, the block latches two phase-current samples and the electrical-angle sin/cos (Q1.15). It performs the Clarke transform and then the Park transform, sharing a single signed multiplier across five sequential multiply steps. It delivers saturated Q1.15 Id/Iq with a one-cycle done pulse to the current PI controllers.

## Interface
- INV_SQRT3 = 18919: 1/√3 in Q0.15 (unsigned).
- W = 16: data width of currents, sin/cos and outputs.
- iClk  in  1  system clock; all logic on the rising edge.
- iRst_n  in  1  asynchronous, active-low reset.
- iEn  in  1  start strobe; sampled only in IDLE.
- iIa, iIb  in  16  signed phase currents a and b, Q1.15.
- iSin, iCos  in  16  signed sin/cos of the electrical angle, Q1.15.
- oId, oIq  out  16  signed direct/quadrature current, Q1.15; registered, held between updates.
- oDone  out  1  one-cycle pulse when oId/oIq update.
- oBusy  out  1  high from the cycle after start acceptance until oDone.

## Operation
- States: IDLE → BETA → D1 → D2 → Q1 → Q2 → OUT → IDLE. Every non-IDLE state lasts exactly one cycle.
- IDLE: when iEn=1, latch iIa, iIb, iSin, iCos into internal registers, set oBusy, and go to BETA. Inputs may change freely after acceptance.
- BETA:
  - s = Ia + 2·Ib (18-bit signed).
  - beta = sat16((s·INV_SQRT3 + 2^14) >>> 15).
  - alpha = Ia.
- D1: acc = alpha·cos (33-bit signed accumulator).
- D2: acc += beta·sin.
  - Id_raw = acc.
- Q1: acc = −(alpha·sin). Negation is taken on the 33-bit product, so no overflow at −32768·−32768.
- Q2: acc += beta·cos.
- OUT:
  - oId = sat16((Id_raw + 2^14) >>> 15).
  - oIq = sat16((acc + 2^14) >>> 15).
  - oDone = 1 for this single cycle; oBusy = 0; return to IDLE.
- Rounding: add 2^14, then arithmetic shift right by 15 (round half toward +∞).
- sat16: clamp to [−32768, +32767].
- Multiplier: one shared signed 18×16 multiplier with muxed operands. The product is combinational into the accumulator within the state; there is no extra pipeline register.
- iEn while oBusy=1, or during OUT, is ignored and not queued. The caller must re-issue it.

## Timing
- Reset values: oId=0, oIq=0, oDone=0, oBusy=0, state=IDLE, all internal registers 0.
- Let iEn be sampled high at edge k in IDLE:
  - oBusy is high after edges k through k+5.
  - oDone and new oId/oIq appear after edge k+6. Latency is 6 cycles.
- Earliest next acceptance is edge k+7, giving a throughput of one transform per 7 cycles. This is well inside one encoder read period.
- oId/oIq change only on the oDone cycle and hold otherwise.
- Reset asserted mid-operation aborts the transform: no oDone, outputs return to 0, and the FSM restarts in IDLE.
- An iEn held continuously high starts a new transform every 7 cycles.

## Structure
- Shared package `foc_pkg` holds:
  - INV_SQRT3_Q15 = 18919;
  - Q15 width W = 16 and the constants SAT_MAX = 32767 and SAT_MIN = −32768;
  - the state encoding for clarke_park.
- Sub-module `q15_round_sat`: combinational, 33-bit signed in → rounded, shifted and saturated 16-bit out. It is instantiated twice at OUT, and its logic is reused for beta.
- The multiplier is inferred once in clarke_park; no separate module.

## Test plan
- Ia=1000, Ib=0, sin=0, cos=32767 → beta=577; oId=1000, oIq=577; oDone exactly 6 cycles after iEn.
- Ia=1000, Ib=0, sin=32767, cos=0 → oId=577, oIq=−1000.
- Ia=Ib=32767, sin=cos=23170 → beta saturates to 32767; oId saturates to 32767; oIq=0.
- Second iEn pulsed 3 cycles after the first, with different inputs → ignored. Only one oDone, carrying the first sample's result; oBusy stays high for edges k..k+5.
- iRst_n pulsed low at edge k+3 of a transform → no oDone, oId=oIq=0, oBusy=0. A new iEn afterwards completes normally in 6 cycles.
- iEn held high for 21 cycles → exactly 3 oDone pulses, spaced 7 cycles apart.
